// File: rtl/ballot_pkg.sv
// ballot_pkg: shared selection/state types, count width shared with voting_machine, and selection helpers
package ballot_pkg;
  localparam int VOTE_CNT_W = 7;
  typedef enum logic [1:0] {SEL_NONE, SEL_A, SEL_B, SEL_C} sel_e;
  typedef enum logic [2:0] {IDLE, READY, SELECTED, COMMIT, LOCKOUT} state_e;
  function automatic sel_e sel_of(input logic [2:0] c);
    return c[0] ? SEL_A : c[1] ? SEL_B : c[2] ? SEL_C : SEL_NONE;
  endfunction
  function automatic logic [2:0] vote_of(input sel_e s);
    return {s == SEL_C, s == SEL_B, s == SEL_A};
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stable-high debouncer and one-cycle registered rising-edge event
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic evt
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, prev_q, prev_d, evt_q, evt_d, hold;
  always_comb begin
    sync_d = {sync_q[0], btn};
    hold = cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    level_d = sync_q[1] & hold;
    cnt_d = !sync_q[1] ? '0 : hold ? cnt_q : cnt_q + 1'b1;
    prev_d = level_q;
    evt_d = level_q & ~prev_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync_q <= '0;
      cnt_q <= '0;
      level_q <= 1'b0;
      prev_q <= 1'b0;
      evt_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
      prev_q <= prev_d;
      evt_q <= evt_d;
    end
  assign evt = evt_q;
endmodule

// File: rtl/ballot_unit.sv
// ballot_unit: one-vote-per-ballot console driving voting_machine; define BALLOT_AUDIT_EN to build the ballots_cast counter
module ballot_unit
  import ballot_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned LOCKOUT_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic issue_ballot,
  input  logic btn_A,
  input  logic btn_B,
  input  logic btn_C,
  input  logic btn_confirm,
  input  logic btn_cancel,
  output logic enable_vote,
  output logic vote_A,
  output logic vote_B,
  output logic vote_C,
  output logic confirm_vote,
  output logic [1:0] selection,
  output logic ballot_ready,
  output logic timeout_err,
  output logic [VOTE_CNT_W-1:0] ballots_cast
);
  localparam int unsigned CMAX = TIMEOUT_CYCLES > LOCKOUT_CYCLES ? TIMEOUT_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned CW = $clog2(CMAX + 1);
  logic [4:0] evt;
  logic [2:0] cand, vote_q, vote_d;
  logic idle_end;
  sel_e pick, sel_q, sel_d;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic enable_q, enable_d, ready_q, ready_d, confirm_q, confirm_d, timeout_q, timeout_d;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [4:0] (
    .clk(clk),
    .reset(reset),
    .btn({btn_cancel, btn_confirm, btn_C, btn_B, btn_A}),
    .evt(evt)
  );
  // cnt is the idle timer in READY/SELECTED and the lockout timer in LOCKOUT
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    vote_d = '0;
    timeout_d = 1'b0;
    cand = evt[2:0];
    pick = $onehot(cand) ? sel_of(cand) : SEL_NONE;
    idle_end = cnt_q == CW'(TIMEOUT_CYCLES - 1);
    case (state_q)
      IDLE:
        if (issue_ballot) begin
          state_d = READY;
          cnt_d = '0;
        end
      READY:
        if (evt[4]) state_d = IDLE;
        else if (pick != SEL_NONE) begin
          state_d = SELECTED;
          sel_d = pick;
          vote_d = vote_of(pick);
          cnt_d = '0;
        end else if (idle_end) begin
          state_d = IDLE;
          timeout_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      SELECTED:
        if (evt[4]) begin
          state_d = READY;
          sel_d = SEL_NONE;
          cnt_d = '0;
        end else if (evt[3]) state_d = COMMIT;
        else if (pick != SEL_NONE && pick != sel_q) begin
          sel_d = pick;
          vote_d = vote_of(pick);
          cnt_d = '0;
        end else if (idle_end) begin
          state_d = IDLE;
          sel_d = SEL_NONE;
          timeout_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      COMMIT: begin
        state_d = LOCKOUT;
        cnt_d = '0;
      end
      LOCKOUT:
        if (cnt_q == CW'(LOCKOUT_CYCLES - 1)) begin
          state_d = IDLE;
          sel_d = SEL_NONE;
        end else cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
    enable_d = state_d != IDLE;
    ready_d = state_d == READY || state_d == SELECTED;
    confirm_d = state_d == COMMIT;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      sel_q <= SEL_NONE;
      cnt_q <= '0;
      vote_q <= '0;
      enable_q <= 1'b0;
      ready_q <= 1'b0;
      confirm_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      vote_q <= vote_d;
      enable_q <= enable_d;
      ready_q <= ready_d;
      confirm_q <= confirm_d;
      timeout_q <= timeout_d;
    end
`ifdef BALLOT_AUDIT_EN
  logic [VOTE_CNT_W-1:0] cast_q, cast_d;
  always_comb cast_d = (confirm_d && !(&cast_q)) ? cast_q + 1'b1 : cast_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cast_q <= '0;
    else cast_q <= cast_d;
  assign ballots_cast = cast_q;
`else
  assign ballots_cast = '0;
`endif
  assign {vote_C, vote_B, vote_A} = vote_q;
  assign enable_vote = enable_q;
  assign confirm_vote = confirm_q;
  assign selection = sel_q;
  assign ballot_ready = ready_q;
  assign timeout_err = timeout_q;
endmodule
